// File: rtl/pixel_pkg.sv
// Shared types and default geometry for the block/stream pixel converters.
// Used by pixel_unshift (and its window-builder counterpart).
package pixel_pkg;

  localparam int PIX_WIDTH = 16;
  localparam int PIX_HOR   = 4;
  localparam int PIX_VER   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/pixel_unshift_if.sv
// Block-in / pixel-stream-out handshake bundle for pixel_unshift.
// slave is the serializer's view, master the block source and sink.
interface pixel_unshift_if
  import pixel_pkg::*;
#(
  parameter int WIDTH    = PIX_WIDTH,
  parameter int HOR_SIZE = PIX_HOR,
  parameter int VER_SIZE = PIX_VER
);

  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] pixel_array_in [HOR_SIZE][VER_SIZE];
  logic [WIDTH-1:0] pixel_out;
  logic             valid_out;
  logic             ready_in;
  logic             first_out;
  logic             last_out;

  modport slave (
    input  valid_in,
    input  pixel_array_in,
    input  ready_in,
    output ready_out,
    output pixel_out,
    output valid_out,
    output first_out,
    output last_out
  );

  modport master (
    output valid_in,
    output pixel_array_in,
    output ready_in,
    input  ready_out,
    input  pixel_out,
    input  valid_out,
    input  first_out,
    input  last_out
  );

endinterface

// File: rtl/pixel_unshift_block_index_counter.sv
// Column-major block index counter: v is fast, h is slow.
// Wraps explicitly so non-power-of-two sizes never exceed SIZE-1.
module block_index_counter #(
  parameter int  HOR_SIZE = 4,
  parameter int  VER_SIZE = 4,
  localparam int HW = $clog2(HOR_SIZE),
  localparam int VW = $clog2(VER_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [HW-1:0] o_h,
  output logic [VW-1:0] o_v,
  output logic          o_first,
  output logic          o_last
);

  localparam logic [HW-1:0] H_MAX = HW'(HOR_SIZE - 1);
  localparam logic [VW-1:0] V_MAX = VW'(VER_SIZE - 1);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [VW-1:0] V_ONE = VW'(1);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_en) begin
      if (r_v == V_MAX) begin
        r_v <= '0;
        r_h <= (r_h == H_MAX) ? '0 : r_h + H_ONE;
      end else begin
        r_v <= r_v + V_ONE;
      end
    end
  end

  assign o_h     = r_h;
  assign o_v     = r_v;
  assign o_first = (r_h == '0) && (r_v == '0);
  assign o_last  = (r_h == H_MAX) && (r_v == V_MAX);

endmodule

// File: rtl/pixel_unshift.sv
// Block-to-stream serializer, column-major order.
// Optional hold buffer for gapless streaming: PIXEL_UNSHIFT_PREFETCH_EN.
module pixel_unshift
  import pixel_pkg::*;
#(
  parameter int  WIDTH    = PIX_WIDTH,
  parameter int  HOR_SIZE = PIX_HOR,
  parameter int  VER_SIZE = PIX_VER,
  localparam int HW = $clog2(HOR_SIZE),
  localparam int VW = $clog2(VER_SIZE)
) (
  input logic             clk_in,
  input logic             rst_in,
  pixel_unshift_if.slave  bus
);

  ser_state_e r_state;
  ser_state_e w_state_nxt;

  logic [WIDTH-1:0] r_active [HOR_SIZE][VER_SIZE];

  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic          w_first;
  logic          w_last;
  logic          w_valid;
  logic          w_ready;
  logic          w_beat;
  logic          w_acc;
  logic          w_load_active;
  logic          w_clr;

`ifdef PIXEL_UNSHIFT_PREFETCH_EN
  logic [WIDTH-1:0] r_hold [HOR_SIZE][VER_SIZE];
  logic             r_hold_full;
  logic             w_load_hold;
  logic             w_hold_to_active;

  assign w_ready = rst_in && !r_hold_full;
`else
  assign w_ready = rst_in && (r_state == IDLE);
`endif

  assign w_valid = rst_in && (r_state == SEND);
  assign w_beat  = w_valid && bus.ready_in;
  assign w_acc   = bus.valid_in && w_ready;

  block_index_counter #(
    .HOR_SIZE (HOR_SIZE),
    .VER_SIZE (VER_SIZE)
  ) u_idx (
    .i_clk   (clk_in),
    .i_rst_n (rst_in),
    .i_en    (w_beat),
    .i_clr   (w_clr),
    .o_h     (w_h),
    .o_v     (w_v),
    .o_first (w_first),
    .o_last  (w_last)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_active = 1'b0;
    w_clr         = 1'b0;
`ifdef PIXEL_UNSHIFT_PREFETCH_EN
    w_load_hold      = 1'b0;
    w_hold_to_active = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_state_nxt   = SEND;
          w_load_active = 1'b1;
          w_clr         = 1'b1;
        end
      end
      SEND: begin
        if (w_beat && w_last) begin
          w_state_nxt = IDLE;
`ifdef PIXEL_UNSHIFT_PREFETCH_EN
          // Chain straight into the next block; counter wraps to [0][0].
          if (r_hold_full) begin
            w_state_nxt      = SEND;
            w_hold_to_active = 1'b1;
          end else if (w_acc) begin
            w_state_nxt   = SEND;
            w_load_active = 1'b1;
          end
`endif
        end
`ifdef PIXEL_UNSHIFT_PREFETCH_EN
        else if (w_acc) begin
          w_load_hold = 1'b1;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_load_active) begin
      r_active <= bus.pixel_array_in;
    end
`ifdef PIXEL_UNSHIFT_PREFETCH_EN
    else if (w_hold_to_active) begin
      r_active <= r_hold;
    end
`endif
  end

`ifdef PIXEL_UNSHIFT_PREFETCH_EN
  always_ff @(posedge clk_in) begin
    if (w_load_hold) r_hold <= bus.pixel_array_in;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in)               r_hold_full <= 1'b0;
    else if (w_load_hold)      r_hold_full <= 1'b1;
    else if (w_hold_to_active) r_hold_full <= 1'b0;
  end
`endif

  assign bus.ready_out = w_ready;
  assign bus.valid_out = w_valid;
  assign bus.pixel_out = r_active[w_h][w_v];
  assign bus.first_out = w_valid && w_first;
  assign bus.last_out  = w_valid && w_last;

endmodule

// File: tb/tb_pixel_unshift.sv
// Directed bench for pixel_unshift (base build; also follows
// PIXEL_UNSHIFT_PREFETCH_EN timing when that macro is defined).
module tb_pixel_unshift;

  localparam int W = 16;
  localparam int H = 4;
  localparam int V = 4;

  typedef logic [W-1:0] blk_t [H][V];

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  bit   pf_mode;

  pixel_unshift_if #(.WIDTH(W), .HOR_SIZE(H), .VER_SIZE(V)) bus ();

  pixel_unshift #(.WIDTH(W), .HOR_SIZE(H), .VER_SIZE(V)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat_chk(input blk_t b, input int k);
    chk($sformatf("valid k%0d", k), 32'(bus.valid_out), 32'd1);
    chk($sformatf("pix k%0d", k), 32'(bus.pixel_out), 32'(b[k/V][k%V]));
    chk($sformatf("first k%0d", k), 32'(bus.first_out), 32'(k == 0));
    chk($sformatf("last k%0d", k), 32'(bus.last_out), 32'(k == H*V-1));
`ifndef PIXEL_UNSHIFT_PREFETCH_EN
    chk($sformatf("rdy_send k%0d", k), 32'(bus.ready_out), 32'd0);
`endif
  endtask

  task automatic run_block(input blk_t b, input bit drop_after_first);
    for (int k = 0; k < H*V; k++) begin
      beat_chk(b, k);
      tick();
      if (drop_after_first && k == 0) bus.valid_in = 1'b0;
    end
  endtask

  function automatic blk_t mk(input int base);
    blk_t b;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < V; j++)
        b[i][j] = W'(base + 16*i + j);
    return b;
  endfunction

  initial begin
    blk_t a, b, c, rb;
    int   cnt, cyc;
    n_cmp = 0;
    n_err = 0;
`ifdef PIXEL_UNSHIFT_PREFETCH_EN
    pf_mode = 1'b1;
`else
    pf_mode = 1'b0;
`endif
    rst = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    a = mk(0);
    bus.pixel_array_in = a;

    tick();
    tick();
    chk("rst valid", 32'(bus.valid_out), 32'd0);
    chk("rst ready", 32'(bus.ready_out), 32'd0);
    chk("rst first", 32'(bus.first_out), 32'd0);
    chk("rst last", 32'(bus.last_out), 32'd0);
    rst = 1'b1;
    #1;
    chk("idle ready", 32'(bus.ready_out), 32'd1);
    chk("idle valid", 32'(bus.valid_out), 32'd0);

    // single block, 0,1,2,3,16,...,51
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    run_block(a, 1'b0);
    chk("t1 end valid", 32'(bus.valid_out), 32'd0);
    chk("t1 end ready", 32'(bus.ready_out), 32'd1);

    // backpressure on beat 5 (value 16)
    b = mk(32'h100);
    bus.pixel_array_in = b;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat_chk(b, k);
      tick();
    end
    bus.ready_in = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp valid", 32'(bus.valid_out), 32'd1);
      chk("bp pix", 32'(bus.pixel_out), 32'h110);
      chk("bp last", 32'(bus.last_out), 32'd0);
    end
    bus.ready_in = 1'b1;
    for (int k = 4; k < H*V; k++) begin
      beat_chk(b, k);
      tick();
    end
    chk("bp end valid", 32'(bus.valid_out), 32'd0);

    // valid_in held while sending
    c = mk(32'h200);
    bus.pixel_array_in = a;
    bus.valid_in = 1'b1;
    tick();
    bus.pixel_array_in = c;
    run_block(a, pf_mode);
`ifndef PIXEL_UNSHIFT_PREFETCH_EN
    chk("held idle valid", 32'(bus.valid_out), 32'd0);
    chk("held idle ready", 32'(bus.ready_out), 32'd1);
    tick();
    bus.valid_in = 1'b0;
`endif
    run_block(c, 1'b0);
    chk("held end valid", 32'(bus.valid_out), 32'd0);

    // reset mid-block after 7 beats
    bus.pixel_array_in = b;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("mid pix", 32'(bus.pixel_out), 32'h113);
    rst = 1'b0;
    tick();
    chk("mid rst valid", 32'(bus.valid_out), 32'd0);
    chk("mid rst first", 32'(bus.first_out), 32'd0);
    chk("mid rst ready", 32'(bus.ready_out), 32'd0);
    rst = 1'b1;
    #1;
    chk("post rst ready", 32'(bus.ready_out), 32'd1);
    bus.pixel_array_in = c;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    run_block(c, 1'b0);

    // random blocks with random backpressure
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < H; i++)
        for (int j = 0; j < V; j++)
          rb[i][j] = W'($urandom);
      bus.pixel_array_in = rb;
      bus.valid_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      chk("rnd start valid", 32'(bus.valid_out), 32'd1);
      cnt = 0;
      cyc = 0;
      while (cnt < H*V && cyc < 200) begin
        bus.ready_in = 1'($urandom_range(0, 1));
        if (bus.valid_out) begin
          chk("rnd pix", 32'(bus.pixel_out), 32'(rb[cnt/V][cnt%V]));
          chk("rnd first", 32'(bus.first_out), 32'(cnt == 0));
          chk("rnd last", 32'(bus.last_out), 32'(cnt == H*V-1));
          if (bus.ready_in) cnt++;
        end
        tick();
        cyc++;
      end
      chk("rnd beats", 32'(cnt), 32'(H*V));
      bus.ready_in = 1'b1;
    end
    chk("rnd end valid", 32'(bus.valid_out), 32'd0);

`ifdef PIXEL_UNSHIFT_PREFETCH_EN
    // three blocks back to back, no gaps
    bus.pixel_array_in = a;
    bus.valid_in = 1'b1;
    tick();
    bus.pixel_array_in = b;
    run_block(a, 1'b1);
    bus.pixel_array_in = c;
    bus.valid_in = 1'b1;
    run_block(b, 1'b1);
    run_block(c, 1'b0);
    chk("pf end valid", 32'(bus.valid_out), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
